// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Package : rst_seq_pkg
// Shared FSM state type and parameter range limits for the reset sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int c_NUM_RST_MIN   = 1;
  localparam int c_NUM_RST_MAX   = 8;
  localparam int c_STABLE_MIN    = 2;
  localparam int c_STABLE_MAX    = 65535;
  localparam int c_STEP_MIN      = 1;
  localparam int c_STEP_MAX      = 65535;
  localparam int c_DEBOUNCE_MIN  = 1;
  localparam int c_DEBOUNCE_MAX  = 65535;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_debounce.sv
// ============================================================================
// Module : rst_seq_debounce
// Two-flop synchroniser followed by a level-acceptance debounce counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rst_seq_debounce #(
  parameter int DebounceCycles = 256,
  parameter int CntW           = 10
) (
  input  logic clk_sys,
  input  logic rst_sys_n,
  input  logic i_async,
  output logic o_level
);

  localparam logic [CntW-1:0] c_LAST = CntW'(DebounceCycles - 1);

  logic            r_meta;
  logic            r_sync;
  logic            r_level;
  logic [CntW-1:0] r_cnt;

  // A sample equal to the accepted level restarts the count, so only an
  // unbroken run of DebounceCycles new-level samples flips the output.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/rst_seq_sonata.sv
// ============================================================================
// Module : rst_seq_sonata
// Staggered release of NumRst active-low resets once lock and board reset are good.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rst_seq_sonata
  import rst_seq_pkg::*;
#(
  parameter int NumRst         = 3,
  parameter int StableCycles   = 1024,
  parameter int StepCycles     = 16,
  parameter int DebounceCycles = 256
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              pll_locked_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NumRst-1:0] rst_n_o,
  output logic              all_released_o,
  output logic              lock_lost_o
);

  localparam int c_CNT_W = $clog2(max3(StableCycles, StepCycles, DebounceCycles)) + 1;
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(StableCycles - 1);
  localparam logic [c_CNT_W-1:0] c_STEP_LAST   = c_CNT_W'(StepCycles - 1);
  localparam logic [NumRst-1:0]  c_BIT0        = NumRst'(1);

  if (NumRst < c_NUM_RST_MIN || NumRst > c_NUM_RST_MAX) begin : g_chk_num_rst
    $error("NumRst out of range");
  end
  if (StableCycles < c_STABLE_MIN || StableCycles > c_STABLE_MAX) begin : g_chk_stable
    $error("StableCycles out of range");
  end
  if (StepCycles < c_STEP_MIN || StepCycles > c_STEP_MAX) begin : g_chk_step
    $error("StepCycles out of range");
  end
  if (DebounceCycles < c_DEBOUNCE_MIN || DebounceCycles > c_DEBOUNCE_MAX) begin : g_chk_debounce
    $error("DebounceCycles out of range");
  end

  logic               r_lock_meta;
  logic               r_lock_sync;
  logic               w_ext_ok;
  logic               w_good;
  state_e             r_state;
  logic [NumRst-1:0]  r_rst_n;
  logic               r_all;
  logic               r_lost;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [NumRst-1:0]  w_rst_shift;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked_i;
      r_lock_sync <= r_lock_meta;
    end
  end

  rst_seq_debounce #(
    .DebounceCycles (DebounceCycles),
    .CntW           (c_CNT_W)
  ) u_ext_debounce (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .i_async   (ext_rst_ni),
    .o_level   (w_ext_ok)
  );

  assign w_good      = r_lock_sync & w_ext_ok;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : (r_cnt + c_CNT_W'(1));
  // Released bits form a thermometer code from bit 0 upward.
  assign w_rst_shift = (r_rst_n << 1) | c_BIT0;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state <= ST_HOLD;
      r_rst_n <= '0;
      r_all   <= 1'b0;
      r_lost  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_rst_n <= '0;
          r_all   <= 1'b0;
          r_cnt   <= '0;
          if (w_good) begin
            r_state <= ST_STABLE;
          end
        end

        ST_STABLE: begin
          if (!w_good) begin
            r_state <= ST_HOLD;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            r_cnt   <= '0;
            r_rst_n <= c_BIT0;
            if (NumRst == 1) begin
              r_state <= ST_RUN;
              r_all   <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_RELEASE: begin
          if (!w_good || sw_rst_req_i) begin
            r_state <= ST_HOLD;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_STEP_LAST) begin
            r_cnt   <= '0;
            r_rst_n <= w_rst_shift;
            if (&w_rst_shift) begin
              r_state <= ST_RUN;
              r_all   <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_RUN: begin
          // Loss of good outranks a coincident software request.
          if (!w_good) begin
            r_state <= ST_HOLD;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_cnt   <= '0;
            r_lost  <= 1'b1;
          end else if (sw_rst_req_i) begin
            r_state <= ST_HOLD;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_rst_n <= '1;
            r_all   <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_HOLD;
          r_rst_n <= '0;
          r_all   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rst_n_o        = r_rst_n;
  assign all_released_o = r_all;
  assign lock_lost_o    = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_sonata.sv
// ============================================================================
// Module : tb_rst_seq_sonata
// Directed scoreboard bench for rst_seq_sonata (NumRst=3, Stable=8, Step=4, Debounce=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq_sonata;

  logic       clk_sys = 1'b0;
  logic       rst_sys_n;
  logic       pll_locked_i;
  logic       ext_rst_ni;
  logic       sw_rst_req_i;
  logic [2:0] rst_n_o;
  logic       all_released_o;
  logic       lock_lost_o;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  rst_seq_sonata #(
    .NumRst         (3),
    .StableCycles   (8),
    .StepCycles     (4),
    .DebounceCycles (4)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_sys_n      (rst_sys_n),
    .pll_locked_i   (pll_locked_i),
    .ext_rst_ni     (ext_rst_ni),
    .sw_rst_req_i   (sw_rst_req_i),
    .rst_n_o        (rst_n_o),
    .all_released_o (all_released_o),
    .lock_lost_o    (lock_lost_o)
  );

  // Observed word is {rst_n_o, all_released_o, lock_lost_o}.
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [2:0] r,
                     input logic a, input logic l);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.exp = {r, a, l};
      sb_q.push_back(e);
      @(posedge clk_sys);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, {rst_n_o, all_released_o, lock_lost_o}, e.exp);
      end
    end
  endtask

  initial begin
    rst_sys_n    = 1'b0;
    pll_locked_i = 1'b1;
    ext_rst_ni   = 1'b1;
    sw_rst_req_i = 1'b0;
    #1;
    check("reset_state", {rst_n_o, all_released_o, lock_lost_o}, 5'b00000);
    run("in_reset", 2, 3'b000, 1'b0, 1'b0);
    rst_sys_n = 1'b1;

    // Scenario 1: 2 sync + 4 debounce + 1 HOLD edge + 8 stable -> bit 0 at edge 15
    run("s1_pre_release", 14, 3'b000, 1'b0, 1'b0);
    run("s1_bit0",         4, 3'b001, 1'b0, 1'b0);
    run("s1_bit1",         4, 3'b011, 1'b0, 1'b0);
    run("s1_all",          1, 3'b111, 1'b1, 1'b0);
    run("s1_run",          2, 3'b111, 1'b1, 1'b0);

    // Scenario 2: two-cycle ext glitch in RUN is filtered
    ext_rst_ni = 1'b0;
    run("s2_glitch", 2, 3'b111, 1'b1, 1'b0);
    ext_rst_ni = 1'b1;
    run("s2_after",  8, 3'b111, 1'b1, 1'b0);

    // Scenario 4: sw request from RUN, ignored in STABLE, then again with only bit 0 out
    sw_rst_req_i = 1'b1;
    run("s4_run_sw", 1, 3'b000, 1'b0, 1'b0);
    sw_rst_req_i = 1'b0;
    run("s4_hold", 3, 3'b000, 1'b0, 1'b0);
    sw_rst_req_i = 1'b1;
    run("s4_stable_sw_ignored", 1, 3'b000, 1'b0, 1'b0);
    sw_rst_req_i = 1'b0;
    run("s4_stable", 4, 3'b000, 1'b0, 1'b0);
    run("s4_bit0",   2, 3'b001, 1'b0, 1'b0);
    sw_rst_req_i = 1'b1;
    run("s4_release_sw", 1, 3'b000, 1'b0, 1'b0);
    sw_rst_req_i = 1'b0;
    run("s4_restart", 8, 3'b000, 1'b0, 1'b0);
    run("s4_rbit0",   4, 3'b001, 1'b0, 1'b0);
    run("s4_rbit1",   4, 3'b011, 1'b0, 1'b0);
    run("s4_rall",    1, 3'b111, 1'b1, 1'b0);

    // Scenario 3: lock loss in RUN asserts all resets on the third edge
    pll_locked_i = 1'b0;
    run("s3_sync_delay", 2, 3'b111, 1'b1, 1'b0);
    run("s3_asserted",   3, 3'b000, 1'b0, 1'b1);
    pll_locked_i = 1'b1;
    run("s3_relock",    10, 3'b000, 1'b0, 1'b1);
    run("s3_bit0",       4, 3'b001, 1'b0, 1'b1);
    run("s3_bit1",       4, 3'b011, 1'b0, 1'b1);
    run("s3_all",        1, 3'b111, 1'b1, 1'b1);
    run("s3_sticky",     3, 3'b111, 1'b1, 1'b1);

    // Scenario 5: lock toggling every 5 cycles never completes STABLE
    pll_locked_i = 1'b0;
    run("s5_sync_delay", 2, 3'b111, 1'b1, 1'b1);
    run("s5_drop",       3, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      pll_locked_i = 1'b1;
      run("s5_toggle_hi", 5, 3'b000, 1'b0, 1'b1);
      pll_locked_i = 1'b0;
      run("s5_toggle_lo", 5, 3'b000, 1'b0, 1'b1);
    end

    // Scenario 6: async block reset in the middle of RELEASE
    pll_locked_i = 1'b1;
    run("s6_relock", 10, 3'b000, 1'b0, 1'b1);
    run("s6_bit0",    2, 3'b001, 1'b0, 1'b1);
    #2;
    rst_sys_n = 1'b0;
    #1;
    check("s6_async_no_edge", {rst_n_o, all_released_o, lock_lost_o}, 5'b00000);
    run("s6_in_reset", 2, 3'b000, 1'b0, 1'b0);
    rst_sys_n = 1'b1;
    run("s6_pre_release", 14, 3'b000, 1'b0, 1'b0);
    run("s6_bit0",         4, 3'b001, 1'b0, 1'b0);
    run("s6_bit1",         4, 3'b011, 1'b0, 1'b0);
    run("s6_all",          1, 3'b111, 1'b1, 1'b0);
    run("s6_run",          3, 3'b111, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/rst_seq_sonata.md
RST_SEQ_SONATA -- requirements
Module: rst_seq_sonata

Interface
REQ-001 Parameter NumRst, default 3: number of sequenced reset outputs, range 1..8.
REQ-002 Parameter StableCycles, default 1024: cycles the lock and external reset must stay good before the first release, range 2..65535.
REQ-003 Parameter StepCycles, default 16: cycles between consecutive releases, range 1..65535.
REQ-004 Parameter DebounceCycles, default 256: cycles external reset must hold a new level before it is accepted, range 1..65535.
REQ-005 clk_sys  input  1  system clock; one clock domain only.
REQ-006 rst_sys_n  input  1  asynchronous, active-low block reset.
REQ-007 pll_locked_i  input  1  PLL lock, asynchronous to clk_sys.
REQ-008 ext_rst_ni  input  1  board reset button, active-low, asynchronous, may bounce.
REQ-009 sw_rst_req_i  input  1  synchronous single-cycle software reset request.
REQ-010 rst_n_o  output  NumRst  sequenced active-low resets; bit 0 is released first.
REQ-011 all_released_o  output  1  high when every rst_n_o bit is 1.
REQ-012 lock_lost_o  output  1  sticky flag: lock fell while in RUN; cleared only by rst_sys_n.

Function
REQ-013 pll_locked_i and ext_rst_ni shall each pass a 2-flop synchroniser; the synchroniser reset value is 0.
REQ-014 Debounce: the accepted external reset level shall change only after the synchronised ext_rst_ni has held the new level for DebounceCycles consecutive cycles; any toggle restarts the count.
REQ-015 "good" = synchronised lock high AND accepted external level high.
REQ-016 FSM states: HOLD, STABLE, RELEASE, RUN.
REQ-017 HOLD: all rst_n_o = 0; go to STABLE on the first cycle "good" is high, with the counter cleared.
REQ-018 STABLE: count while good; after StableCycles consecutive good cycles, release bit 0 and go to RELEASE.
REQ-019 RELEASE: every StepCycles cycles release the next bit (lowest unreleased index); go to RUN on the cycle the final bit is released. If NumRst = 1, go directly from STABLE to RUN.
REQ-020 RUN: hold all outputs at 1.
REQ-021 From any state other than HOLD, "good" low shall drive all rst_n_o to 0 and enter HOLD on the next edge. Synchroniser latency is 2 cycles; worst-case assertion latency from the pin is 3 cycles.
REQ-022 sw_rst_req_i in RUN or RELEASE shall enter HOLD with all outputs 0. The resulting sequence re-runs from STABLE, so the reset is held for at least StableCycles+1 cycles. sw_rst_req_i is ignored in HOLD and STABLE.
REQ-023 Loss of good and sw_rst_req_i in the same cycle: behave as loss of good; lock_lost_o is set if the state was RUN.
REQ-024 Released bits shall never re-assert individually; assertion is always all bits together.
REQ-025 rst_n_o and all_released_o shall be registered outputs, glitch-free.
REQ-026 Counter width shall be $clog2 of the largest of StableCycles, StepCycles and DebounceCycles, plus 1. The counter shall saturate, never wrap.

Reset
REQ-027 On rst_sys_n low, asynchronously: FSM = HOLD, rst_n_o = 0, all_released_o = 0, lock_lost_o = 0, counters = 0, accepted external level = 0 (in reset).
REQ-028 Reset mid-sequence shall abort the sequence; after rst_sys_n rises, the full HOLD -> STABLE -> RELEASE flow restarts.

Structure
REQ-029 Package rst_seq_pkg shall hold the FSM state enum and the parameter range limits.
REQ-030 Sub-module rst_seq_debounce shall contain the synchroniser plus debounce counter; it is instantiated once for ext_rst_ni. pll_locked_i uses a synchroniser only.

Verification
REQ-031 Bench parameters: NumRst = 3, StableCycles = 8, StepCycles = 4, DebounceCycles = 4.
REQ-032 Scenario 1: lock and ext high from reset release. Required: rst_n_o[0] rises at cycle 2+4+8 (+/-1 for FSM edge); bits 1 and 2 follow at +4 and +8; all_released_o rises with bit 2.
REQ-033 Scenario 2: ext_rst_ni glitches low for 2 cycles during RUN. Required: no output change.
REQ-034 Scenario 3: pll_locked_i drops in RUN. Required: rst_n_o = 3'b000 within 3 cycles; lock_lost_o = 1 and stays 1 after lock returns and the sequence completes.
REQ-035 Scenario 4: sw_rst_req_i pulse while only bit 0 is released. Required: rst_n_o = 000 next cycle; the sequence restarts; lock_lost_o stays 0.
REQ-036 Scenario 5: lock toggles every 5 cycles. Required: rst_n_o stays 000 throughout (STABLE never completes).
REQ-037 Scenario 6: rst_sys_n asserted mid-RELEASE. Required: outputs 0 immediately, without a clock edge; a clean restart follows release.
